// File: rtl/la_ioring_pkg.sv
// Shared definitions for the IO ring controller: FSM states and the bit
// positions of the control signals on the io-ring bus.
package la_ioring_pkg;

  typedef enum logic [1:0] {
    PWRUP = 2'd0,
    IDLE  = 2'd1,
    SHIFT = 2'd2,
    LOAD  = 2'd3
  } state_t;

  localparam int RING_SDATA = 0;
  localparam int RING_SCLK  = 1;
  localparam int RING_LOAD  = 2;
  localparam int RING_IOEN  = 3;

endpackage

// File: rtl/la_ioring_shifter.sv
// Serialiser for the ring config chain. Walks the concatenated config words
// from the top bit of the highest pad down to bit 0 of pad 0, two cycles per
// bit: phase A presents sdata with sclk low, phase B raises sclk.
module la_ioring_shifter #(
  parameter int NPADS = 16,
  parameter int CFGW  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run,
  input  logic [NPADS-1:0][CFGW-1:0]  cfg,
  output logic                        sdata,
  output logic                        sclk,
  output logic                        last
);

  localparam int NB = NPADS * CFGW;
  localparam int BW = $clog2(NB);

  logic [BW-1:0] bitcnt;
  logic          phase;   // 0 = phase A, 1 = phase B
  logic [NB-1:0] chain;
  logic [BW-1:0] sel;

  // Packed pad array flattens with pad NPADS-1 at the top, so the chain is
  // simply consumed from its MSB downward.
  assign chain = cfg;
  assign sel   = BW'(NB - 1) - bitcnt;

  // Phase toggles every cycle while running; the bit index steps after phase B
  // and returns to 0 only when the chain is exhausted or the shift is left.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      bitcnt <= '0;
      phase  <= 1'b0;
    end else begin
      phase <= ~phase;
      if (phase)
        bitcnt <= last ? '0 : bitcnt + 1'b1;
    end
  end

  // Regfile is frozen while shifting (writes are refused), so the live read
  // only changes when bitcnt moves, i.e. entering phase A.
  assign sclk  = run && phase;
  assign sdata = run && chain[sel];
  assign last  = run && phase && (bitcnt == BW'(NB - 1));

endmodule

// File: rtl/la_ioring_ctrl.sv
// IO ring sequencer: per-pad config register file, power-up settle delay,
// serial config shift down the ring chain and a final load strobe.
module la_ioring_ctrl
  import la_ioring_pkg::*;
#(
  parameter int NPADS  = 16,
  parameter int CFGW   = 8,
  parameter int RINGW  = 8,
  parameter int SETTLE = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [$clog2(NPADS)-1:0] cfg_addr,
  input  logic [CFGW-1:0]          cfg_wdata,
  output logic [CFGW-1:0]          cfg_rdata,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_werr,
  output logic [RINGW-1:0]         ring_out
);

  localparam int AW = $clog2(NPADS);
  localparam int SW = $clog2(SETTLE) + 1;

  state_t                      state;
  logic [SW-1:0]               settle_cnt;
  logic                        io_en;
  logic [NPADS-1:0][CFGW-1:0]  cfg;
  logic                        addr_ok;
  logic                        wr_ok;
  logic                        sdata;
  logic                        sclk;
  logic                        last;

  assign addr_ok = int'(cfg_addr) < NPADS;
  assign wr_ok   = cfg_we && addr_ok && (state == IDLE);
  assign busy    = (state != IDLE);

  // One register per pad; only an in-range write while idle reaches it.
  for (genvar g = 0; g < NPADS; g++) begin : g_cfg
    always_ff @(posedge clk) begin
      if (reset)
        cfg[g] <= '0;
      else if (wr_ok && (cfg_addr == AW'(g)))
        cfg[g] <= cfg_wdata;
    end
  end

  // Sequencer: settle count, io_en latch, shift/load handshaking and the
  // done / write-error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PWRUP;
      settle_cnt <= '0;
      io_en      <= 1'b0;
      done       <= 1'b0;
      cfg_werr   <= 1'b0;
    end else begin
      done     <= 1'b0;
      cfg_werr <= cfg_we && !wr_ok;
      unique case (state)
        PWRUP: begin
          if (settle_cnt == SW'(SETTLE - 1)) begin
            io_en <= 1'b1;
            state <= IDLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        IDLE:  if (start) state <= SHIFT;
        SHIFT: if (last)  state <= LOAD;
        LOAD: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= PWRUP;
      endcase
    end
  end

  la_ioring_shifter #(
    .NPADS (NPADS),
    .CFGW  (CFGW)
  ) u_shifter (
    .clk   (clk),
    .reset (reset),
    .run   (state == SHIFT),
    .cfg   (cfg),
    .sdata (sdata),
    .sclk  (sclk),
    .last  (last)
  );

  // Out-of-range reads return zero rather than aliasing onto a real pad.
  always_comb begin
    cfg_rdata = '0;
    if (addr_ok)
      cfg_rdata = cfg[cfg_addr];
  end

  // Ring bus: unused upper bits stay tied low.
  always_comb begin
    ring_out             = '0;
    ring_out[RING_SDATA] = sdata;
    ring_out[RING_SCLK]  = sclk;
    ring_out[RING_LOAD]  = (state == LOAD);
    ring_out[RING_IOEN]  = io_en;
  end

endmodule

// File: tb/tb_la_ioring_ctrl.sv
// Bench for la_ioring_ctrl: a scoreboard of expected serial bits is filled
// when a shift is launched and drained by a monitor on every sclk-high cycle.
module tb_la_ioring_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we, start;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata, cfg_rdata, ring_out;
  logic       busy, done, cfg_werr;

  // Second instance with a non power-of-two pad count so an out-of-range
  // address can actually be presented.
  logic       we5, start5;
  logic [2:0] addr5;
  logic [7:0] wdata5, rdata5, ring5;
  logic       busy5, done5, werr5;

  int tests = 0;
  int fails = 0;
  int load_cnt = 0;
  int done_cnt = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  la_ioring_ctrl #(.NPADS(4), .CFGW(8), .RINGW(8), .SETTLE(64)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .start(start),
    .busy(busy), .done(done), .cfg_werr(cfg_werr), .ring_out(ring_out)
  );

  la_ioring_ctrl #(.NPADS(5), .CFGW(8), .RINGW(8), .SETTLE(2)) u5 (
    .clk(clk), .reset(reset), .cfg_we(we5), .cfg_addr(addr5),
    .cfg_wdata(wdata5), .cfg_rdata(rdata5), .start(start5),
    .busy(busy5), .done(done5), .cfg_werr(werr5), .ring_out(ring5)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp);
    cfg_addr = a;
    #1;
    chk("cfg_rdata", cfg_rdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d, input logic exp_err);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    chk("cfg_werr", cfg_werr, exp_err);
  endtask

  task automatic push_stream(input logic [31:0] s);
    for (int i = 31; i >= 0; i--) exp_q.push_back(s[i]);
  endtask

  // Monitor: every sclk-high cycle consumes one expected bit; also counts
  // load strobes and done pulses.
  always @(negedge clk) begin
    if (ring_out[1]) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_extra_bit: got sdata %0b expected no shift", ring_out[0]);
      end else begin
        chk("sb_sdata", ring_out[0], exp_q.pop_front());
      end
    end
    if (ring_out[2]) load_cnt++;
    if (done)        done_cnt++;
  end

  // Runs after the cycle where start was sampled. extras: stray start and a
  // refused write mid-shift. abort_k >= 0: reset at that shift cycle.
  task automatic shift_body(input bit extras, input int abort_k);
    int k;
    k = 0;
    while (!ring_out[2] && k < 200) begin
      if (k == abort_k) begin
        reset = 1'b1;
        exp_q.delete();
        tick();
        chk("abort_ring", ring_out, 32'h0);
        chk("abort_busy", busy, 1);
        chk("abort_done", done, 0);
        for (int p = 0; p < 4; p++) rd(2'(p), 8'h00);
        reset = 1'b0;
        return;
      end
      if (extras) begin
        if (k == 10) start = 1'b1;
        if (k == 11) start = 1'b0;
        if (k == 20) begin cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 8'hFF; end
        if (k == 21) begin cfg_we = 1'b0; chk("werr_shift", cfg_werr, 1); end
        if (k == 22) chk("werr_pulse_end", cfg_werr, 0);
      end
      if (k == 5) chk("busy_shift", busy, 1);
      tick();
      k++;
    end
    chk("load_latency", k, 64);
    chk("load_sclk", ring_out[1], 0);
    chk("load_sdata", ring_out[0], 0);
    tick();
    chk("done_pulse", done, 1);
    chk("busy_after", busy, 0);
    chk("load_gone", ring_out[2], 0);
    tick();
    chk("done_end", done, 0);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; cfg_we = 1'b0; start = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    we5 = 1'b0; start5 = 1'b0; addr5 = '0; wdata5 = '0;
    tick(); tick(); tick();
    chk("rst_ring", ring_out, 32'h0);
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_werr", cfg_werr, 0);
    rd(2'd0, 8'h00);

    // Power-up: count cycles until io_en, with stray start/write in PWRUP.
    reset = 1'b0;
    n = 0;
    while (!ring_out[3] && n < 200) begin
      if (n == 5) begin start = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 8'h11; end
      if (n == 6) begin
        start = 1'b0; cfg_we = 1'b0;
        chk("werr_pwrup", cfg_werr, 1);
        chk("busy_pwrup", busy, 1);
      end
      if (n == 7) chk("werr_pwrup_end", cfg_werr, 0);
      if (n == 10) begin we5 = 1'b1; addr5 = 3'd5; wdata5 = 8'hAA; end
      if (n == 11) begin
        we5 = 1'b0;
        chk("werr_badaddr", werr5, 1);
        #1 chk("rdata_badaddr", rdata5, 8'h00);
      end
      if (n == 12) begin we5 = 1'b1; addr5 = 3'd4; wdata5 = 8'h99; end
      if (n == 13) begin
        we5 = 1'b0;
        chk("werr_goodaddr", werr5, 0);
        #1 chk("rdata_pad4", rdata5, 8'h99);
        addr5 = 3'd7;
        #1 chk("rdata_addr7", rdata5, 8'h00);
      end
      if (n == 20) chk("ring_pwrup", ring_out, 32'h0);
      tick();
      n++;
    end
    chk("settle_len", n, 64);
    chk("ring_idle", ring_out, 32'h08);
    chk("busy_idle", busy, 0);
    rd(2'd0, 8'h00);

    wr(2'd0, 8'hA5, 0);
    wr(2'd1, 8'h3C, 0);
    wr(2'd2, 8'h0F, 0);
    wr(2'd3, 8'h81, 0);
    rd(2'd2, 8'h0F);
    rd(2'd3, 8'h81);

    // Full shift with stray start and refused write in flight.
    push_stream(32'h810F3CA5);
    start = 1'b1;
    tick();
    start = 1'b0;
    shift_body(1'b1, -1);
    rd(2'd2, 8'h0F);
    tick(); tick();
    chk("one_load", load_cnt, 1);
    chk("one_done", done_cnt, 1);

    // Write and start in the same idle cycle: new data is shifted.
    push_stream(32'h810F55A5);
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 8'h55; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    chk("werr_same_cycle", cfg_werr, 0);
    shift_body(1'b0, -1);
    rd(2'd1, 8'h55);

    // Reset during bit 20 phase A: everything clears, no load or done.
    push_stream(32'h810F55A5);
    start = 1'b1;
    tick();
    start = 1'b0;
    shift_body(1'b0, 40);
    for (int i = 0; i < 5; i++) tick();
    chk("abort_loads", load_cnt, 2);
    chk("abort_dones", done_cnt, 2);
    chk("abort_ioen", ring_out[3], 0);
    chk("abort_pwrup", busy, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
